round_key_scheduler: RTL and testbench

Sequential AES-128 round-key controller that replaces the fully unrolled ten-stage expander with one shared `h_module` round-step instance, iterated once per clock. It accepts a cipher key over a valid/ready handshake and generates round keys 0..10 into an internal 11×128 key store. It then serves them to the cipher core through a request/valid read port, allowing early reads of rounds that have already been produced.

---
 rtl/round_key_scheduler.sv | 173 +++++++++++++++++
 tb/tb_round_key_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_key_scheduler.sv
// AES-128 round-key controller: one shared key-expansion round step iterated per clock,
// filling an 11-entry key store that the cipher core can read (early) over a req/valid port.

module h_module (
  input  logic [127:0] h_in,
  input  logic [3:0]   h_round_in,
  output logic [127:0] h_out,
  output logic [3:0]   h_round_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box = affine(x^254): x^254 is the GF(2^8) inverse, with 0 mapping to 0.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;
  logic [7:0]  rcon;

  always_comb begin
    case (h_round_in)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
    w0 = h_in[127:96];
    w1 = h_in[95:64];
    w2 = h_in[63:32];
    w3 = h_in[31:0];
    temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h000000};
    n0 = w0 ^ temp;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    h_out = {n0, n1, n2, n3};
  end

  assign h_round_out = h_round_in + 4'd1;

endmodule

module round_key_scheduler #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] cipher_key,
  output logic         keys_ready,
  output logic         busy,
  input  logic         rk_req,
  input  logic [3:0]   rk_idx,
  output logic         rk_valid,
  output logic [127:0] rk_data,
  output logic         rk_err
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NR);
  localparam logic [3:0] LAST_RND = 4'(NR - 1);

  state_t       state, state_nxt;
  logic [127:0] store [0:NR];
  logic [127:0] cur_key, h_out, wr_dat, rd_dat;
  logic [3:0]   round_cnt, avail, avail_nxt, wr_idx, rd_sel, round_unused;
  logic         accept, wr_en, rd_hit, rd_oob;

  h_module u_h (
    .h_in        (cur_key),
    .h_round_in  (round_cnt),
    .h_out       (h_out),
    .h_round_out (round_unused)
  );

  assign key_ready  = (state == IDLE) || (state == DONE);
  assign busy       = (state == EXPAND);
  assign keys_ready = (state == DONE);
  assign accept     = key_valid && key_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXPAND;
      EXPAND:  if (round_cnt == LAST_RND) state_nxt = DONE;
      DONE:    if (accept) state_nxt = EXPAND;
      default: state_nxt = IDLE;
    endcase
  end

  // Reads are judged against the post-edge avail and see this cycle's store write,
  // so a waiting request is answered on the very edge its entry lands.
  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = 4'd0;
    wr_dat    = h_out;
    avail_nxt = avail;
    if (accept) begin
      wr_en     = 1'b1;
      wr_dat    = cipher_key;
      avail_nxt = 4'd1;
    end else if (state == EXPAND) begin
      wr_en     = 1'b1;
      wr_idx    = round_cnt + 4'd1;
      avail_nxt = avail + 4'd1;
    end
    rd_oob = rk_req && (rk_idx > LAST_IDX);
    rd_hit = rk_req && !rd_oob && (rk_idx < avail_nxt);
    rd_sel = rd_oob ? 4'd0 : rk_idx;
    rd_dat = (wr_en && (wr_idx == rd_sel)) ? wr_dat : store[rd_sel];
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) store[wr_idx] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_key   <= '0;
      round_cnt <= 4'd0;
      avail     <= 4'd0;
      rk_valid  <= 1'b0;
      rk_err    <= 1'b0;
      rk_data   <= '0;
    end else begin
      if (accept) begin
        cur_key   <= cipher_key;
        round_cnt <= 4'd0;
      end else if (state == EXPAND) begin
        cur_key   <= h_out;
        round_cnt <= round_cnt + 4'd1;
      end
      avail    <= avail_nxt;
      rk_valid <= rd_hit || rd_oob;
      rk_err   <= rd_oob;
      rk_data  <= rd_hit ? rd_dat : '0;
    end
  end

endmodule

// File: tb/tb_round_key_scheduler.sv
// Randomized bench for round_key_scheduler against a word-level FIPS-197 key expansion model.

module tb_round_key_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] cipher_key;
  logic         keys_ready;
  logic         busy;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic         rk_err;

  always #5 clk = ~clk;

  round_key_scheduler #(.NR(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .cipher_key (cipher_key),
    .keys_ready (keys_ready),
    .busy       (busy),
    .rk_req     (rk_req),
    .rk_idx     (rk_idx),
    .rk_valid   (rk_valid),
    .rk_data    (rk_data),
    .rk_err     (rk_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [0:255][7:0] sbox_tab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic [127:0] ref_rk [0:10];
  logic [127:0] fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] k_a, k_b;
  int           n, r;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Textbook word-by-word expansion: w[i] = w[i-4] ^ f(w[i-1]).
  task automatic ref_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]} ^ {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) ref_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  task automatic load_key(input logic [127:0] k);
    int c;
    c = 0;
    while (!key_ready && c < 50) begin
      tick;
      c++;
    end
    if (!key_ready) chk("key_ready_timeout", 128'(key_ready), 128'd1);
    key_valid  = 1'b1;
    cipher_key = k;
    tick;
    key_valid  = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (!keys_ready && c < 40) begin
      tick;
      c++;
    end
  endtask

  task automatic read_chk(input logic [3:0] idx, input logic [127:0] exp, input logic err, input string tag);
    rk_req = 1'b1;
    rk_idx = idx;
    tick;
    rk_req = 1'b0;
    chk({tag, "_valid"}, 128'(rk_valid), 128'd1);
    chk({tag, "_err"}, 128'(rk_err), 128'(err));
    chk({tag, "_data"}, rk_data, exp);
  endtask

  // Back-to-back reads of all rounds in a permuted order against ref_rk.
  task automatic read_all(input int off);
    logic [3:0] idx;
    rk_req = 1'b1;
    for (int i = 0; i < 11; i++) begin
      idx    = 4'((i * 7 + off) % 11);
      rk_idx = idx;
      tick;
      chk("b2b_valid", 128'(rk_valid), 128'd1);
      chk("b2b_data", rk_data, ref_rk[idx]);
    end
    rk_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    key_valid  = 1'b0;
    cipher_key = '0;
    rk_req     = 1'b0;
    rk_idx     = 4'd0;
    tick;
    tick;
    chk("rst_key_ready", 128'(key_ready), 128'd1);
    chk("rst_keys_ready", 128'(keys_ready), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rk_valid", 128'(rk_valid), 128'd0);
    chk("rst_rk_err", 128'(rk_err), 128'd0);
    chk("rst_rk_data", rk_data, 128'd0);
    rst = 1'b0;
    tick;

    // FIPS-197 key
    load_key(fips_key);
    chk("fips_busy", 128'(busy), 128'd1);
    chk("fips_key_ready_low", 128'(key_ready), 128'd0);
    wait_done(n);
    chk("fips_latency", 128'(n), 128'd10);
    chk("fips_busy_done", 128'(busy), 128'd0);
    read_chk(4'd0, fips_key, 1'b0, "fips_r0");
    read_chk(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0, "fips_r1");
    read_chk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, "fips_r10");
    ref_expand(fips_key);
    read_all(3);
    read_chk(4'd11, 128'd0, 1'b1, "oob11");
    read_chk(4'd15, 128'd0, 1'b1, "oob15");

    // Rekey from DONE with the all-zero key
    load_key(128'd0);
    chk("rekey_keys_ready_drop", 128'(keys_ready), 128'd0);
    wait_done(n);
    chk("rekey_latency", 128'(n), 128'd10);
    read_chk(4'd1, 128'h62636363626363636263636362636363, 1'b0, "zero_r1");
    read_chk(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b0, "zero_r10");

    // Early read of round 5 stalls until the entry is produced
    load_key(fips_key);
    rk_req = 1'b1;
    rk_idx = 4'd5;
    n = 0;
    while (!rk_valid && n < 20) begin
      tick;
      n++;
    end
    rk_req = 1'b0;
    chk("early_wait", 128'(n), 128'd5);
    chk("early_r5", rk_data, 128'hd4d1c6f87c839d87caf2b8bc11f915bc);
    wait_done(n);

    // Reset mid-expansion, pending read, then restart
    k_a = {$urandom, $urandom, $urandom, $urandom};
    k_b = {$urandom, $urandom, $urandom, $urandom};
    load_key(k_a);
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_keys_ready", 128'(keys_ready), 128'd0);
    chk("midrst_key_ready", 128'(key_ready), 128'd1);
    rk_req = 1'b1;
    rk_idx = 4'd0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("midrst_pending", 128'(rk_valid), 128'd0);
    end
    load_key(k_b);
    rk_req = 1'b0;
    chk("restart_read_valid", 128'(rk_valid), 128'd1);
    chk("restart_read_data", rk_data, k_b);
    wait_done(n);
    chk("restart_latency", 128'(n), 128'd10);
    ref_expand(k_b);
    read_all(5);

    // key_valid held through expansion is ignored until DONE
    k_a = {$urandom, $urandom, $urandom, $urandom};
    k_b = {$urandom, $urandom, $urandom, $urandom};
    key_valid  = 1'b1;
    cipher_key = k_a;
    tick;
    cipher_key = k_b;
    for (int i = 0; i < 10; i++) begin
      chk("gate_key_ready", 128'(key_ready), 128'd0);
      tick;
    end
    chk("gate_keys_ready", 128'(keys_ready), 128'd1);
    chk("gate_key_ready_done", 128'(key_ready), 128'd1);
    tick;
    key_valid = 1'b0;
    chk("gate_second_accept", 128'(busy), 128'd1);
    wait_done(n);
    chk("gate_latency", 128'(n), 128'd10);
    ref_expand(k_b);
    read_all(1);

    // Random keys, each loaded from DONE together with a read that must wait for its entry
    for (int it = 0; it < 5; it++) begin
      k_a = {$urandom, $urandom, $urandom, $urandom};
      r   = $urandom_range(0, 10);
      ref_expand(k_a);
      rk_req     = 1'b1;
      rk_idx     = 4'(r);
      key_valid  = 1'b1;
      cipher_key = k_a;
      tick;
      key_valid = 1'b0;
      n = 0;
      while (!rk_valid && n < 20) begin
        tick;
        n++;
      end
      rk_req = 1'b0;
      chk("rnd_wait", 128'(n), 128'(r));
      chk("rnd_early_data", rk_data, ref_rk[r]);
      begin
        int m;
        wait_done(m);
        chk("rnd_latency", 128'(n + m), 128'd10);
      end
      read_all(it);
      read_chk(4'($urandom_range(11, 15)), 128'd0, 1'b1, "rnd_oob");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
